// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the IF-stage program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: the pc_state_t state encoding, the default width and reset PC, the
// next-PC select encoding, and npc_select(), which applies the RUN-state priority
// list (halt > jump > branch > stall > increment).
package pc_seq_pkg;

   localparam int PC_WIDTH_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Plain 2-bit encoding so the values survive unchanged into netlists and dumps.
   typedef logic [1:0] pc_state_t;
   localparam pc_state_t IDLE      = 2'd0;
   localparam pc_state_t RUN       = 2'd1;
   localparam pc_state_t HALT      = 2'd2;
   localparam pc_state_t STEP_WAIT = 2'd3;

   typedef logic [1:0] npc_sel_t;
   localparam npc_sel_t NPC_HOLD = 2'd0;
   localparam npc_sel_t NPC_INC  = 2'd1;
   localparam npc_sel_t NPC_BR   = 2'd2;
   localparam npc_sel_t NPC_JMP  = 2'd3;

   // A redirect beats a stall: the stalled slot is squashed downstream.
   function automatic npc_sel_t npc_select(input logic halt,
                                           input logic jump,
                                           input logic branch,
                                           input logic stall);
      npc_sel_t sel;
      if (halt)        sel = NPC_HOLD;
      else if (jump)   sel = NPC_JMP;
      else if (branch) sel = NPC_BR;
      else if (stall)  sel = NPC_HOLD;
      else             sel = NPC_INC;
      return sel;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Interface bundling the sequencer's control inputs and PC/status outputs.
// Latency: n/a (wires only).
// Backpressure: none; stall_i from the hazard unit is the only hold request.
// Modports:
//   master - the sequencer: consumes control/targets/pc_inc_i, drives pc_o and status.
//   slave  - the pipeline side (incrementer, hazard, branch/jump resolution, debug unit).
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int CNT_WIDTH = 32
);
   logic                 enable_i;
   logic [PC_WIDTH-1:0]  pc_inc_i;
   logic                 stall_i;
   logic                 branch_taken_i;
   logic [PC_WIDTH-1:0]  branch_target_i;
   logic                 jump_i;
   logic [PC_WIDTH-1:0]  jump_target_i;
   logic                 halt_i;
   logic                 step_i;
   logic [PC_WIDTH-1:0]  pc_o;
   logic                 fetch_valid_o;
   logic                 halted_o;
   logic [CNT_WIDTH-1:0] fetch_cnt_o;

   modport master (
      input  enable_i, pc_inc_i, stall_i, branch_taken_i, branch_target_i,
             jump_i, jump_target_i, halt_i, step_i,
      output pc_o, fetch_valid_o, halted_o, fetch_cnt_o
   );

   modport slave (
      output enable_i, pc_inc_i, stall_i, branch_taken_i, branch_target_i,
             jump_i, jump_target_i, halt_i, step_i,
      input  pc_o, fetch_valid_o, halted_o, fetch_cnt_o
   );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clear wins over inc.
// Latency: 1 cycle from inc/clear to count.
// Backpressure: none; an inc while saturated is dropped.
// Ports: clk, clear (synchronous), inc, count[WIDTH-1:0].
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and fetch sequencer of the IF stage.
// Latency: a redirect/increment sampled at edge N appears on pc_o after edge N; all outputs registered.
// Backpressure: stall_i holds the PC (redirects still apply); halt is sticky until reset_n.
// Ports: clk, reset_n (synchronous, active-low), bus (pc_sequencer_if.master):
//   control/targets in (enable_i, stall_i, branch_*, jump_*, halt_i, step_i, pc_inc_i),
//   pc_o, fetch_valid_o, halted_o, fetch_cnt_o out.
// Build option: PC_STEP_EN - the run state becomes STEP_WAIT and the PC makes one
// update per cycle with step_i high; without it step_i is ignored.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEF),
   parameter int                  CNT_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   pc_sequencer_if.master    bus
);

`ifdef PC_STEP_EN
   localparam pc_state_t ACTIVE = STEP_WAIT;
`else
   localparam pc_state_t ACTIVE = RUN;
`endif

   pc_state_t           state;
   pc_state_t           state_nxt;
   npc_sel_t            sel;
   logic                active;
   logic                fetch_valid_nxt;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic                fetch_valid;
   logic                halted;
   logic                unused_step;

   // In the default build every RUN cycle may update; in step mode only step_i cycles do.
`ifdef PC_STEP_EN
   assign active      = bus.step_i;
   assign unused_step = 1'b0;
`else
   assign active      = 1'b1;
   assign unused_step = bus.step_i;
`endif

   always_comb begin
      state_nxt = state;
      sel       = NPC_HOLD;
      case (state)
         IDLE: begin
            // The PC does not move on the edge that starts execution.
            if (bus.enable_i) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (active) begin
               sel = npc_select(bus.halt_i, bus.jump_i, bus.branch_taken_i, bus.stall_i);
               if (bus.halt_i) begin
                  state_nxt = HALT;
               end else if (!bus.enable_i) begin
                  // Leaving run: a pending redirect still lands, a plain increment does not.
                  state_nxt = IDLE;
                  if (sel == NPC_INC) sel = NPC_HOLD;
               end
            end else if (!bus.enable_i) begin
               state_nxt = IDLE;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      case (sel)
         NPC_INC: pc_nxt = bus.pc_inc_i;
         NPC_BR:  pc_nxt = bus.branch_target_i;
         NPC_JMP: pc_nxt = bus.jump_target_i;
         default: pc_nxt = pc;
      endcase
   end

   // fetch_valid describes the cycle that follows the edge: registered view of
   // "in run and not stalled". In step mode only an actual step cycle fetches.
`ifdef PC_STEP_EN
   assign fetch_valid_nxt = (state == ACTIVE) && (state_nxt == ACTIVE) && active && !bus.stall_i;
`else
   assign fetch_valid_nxt = (state_nxt == ACTIVE) && !bus.stall_i;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         fetch_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         fetch_valid <= fetch_valid_nxt;
         halted      <= (state_nxt == HALT);
      end
   end

   // Every PC load counts, including a redirect to the current address.
   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_fetch_cnt (
      .clk   (clk),
      .clear (!reset_n),
      .inc   (sel != NPC_HOLD),
      .count (bus.fetch_cnt_o)
   );

   assign bus.pc_o          = pc;
   assign bus.fetch_valid_o = fetch_valid;
   assign bus.halted_o      = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
// A second instance with a 4-bit counter exercises fetch-count saturation.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, stall = 1'b0, br = 1'b0, jmp = 1'b0, halt = 1'b0, step = 1'b0;
   logic [31:0] bt = '0, jt = '0, skew = '0;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state, in spec terms: 0 idle, 1 running, 2 halted.
   int          m_mode = 0;
   logic [31:0] m_pc   = '0;
   logic [31:0] m_cnt  = '0;
   int          m_cnt_s = 0;
   logic        m_fv   = 1'b0;
   logic        m_halt = 1'b0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();
   pc_sequencer_if #(.PC_WIDTH(32), .CNT_WIDTH(4))  bus_s ();

   assign bus.enable_i        = en;
   assign bus.stall_i         = stall;
   assign bus.branch_taken_i  = br;
   assign bus.branch_target_i = bt;
   assign bus.jump_i          = jmp;
   assign bus.jump_target_i   = jt;
   assign bus.halt_i          = halt;
   assign bus.step_i          = step;
   assign bus.pc_inc_i        = bus.pc_o + 32'd1 + skew;

   assign bus_s.enable_i        = en;
   assign bus_s.stall_i         = stall;
   assign bus_s.branch_taken_i  = br;
   assign bus_s.branch_target_i = bt;
   assign bus_s.jump_i          = jmp;
   assign bus_s.jump_target_i   = jt;
   assign bus_s.halt_i          = halt;
   assign bus_s.step_i          = step;
   assign bus_s.pc_inc_i        = bus_s.pc_o + 32'd1 + skew;

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(4)) dut_s (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Applies one clock edge of the specified behaviour to the reference state.
   task automatic model_step();
      logic        upd;
      logic        may;
      logic [31:0] nxt;
      int          old_mode;
      upd = 1'b0;
      nxt = m_pc;
      old_mode = m_mode;
`ifdef PC_STEP_EN
      may = step;
`else
      may = 1'b1;
`endif
      if (!rst_n) begin
         m_mode = 0; m_pc = '0; m_cnt = '0; m_cnt_s = 0; m_fv = 1'b0; m_halt = 1'b0;
         return;
      end
      if (m_mode == 0) begin
         if (en) m_mode = 1;
      end else if (m_mode == 1) begin
         if (may && halt) begin
            m_mode = 2;
         end else begin
            if (may) begin
               if (jmp)                begin nxt = jt;             upd = 1'b1; end
               else if (br)            begin nxt = bt;             upd = 1'b1; end
               else if (!stall && en)  begin nxt = m_pc + 1 + skew; upd = 1'b1; end
            end
            if (!en) m_mode = 0;
         end
      end
`ifdef PC_STEP_EN
      m_fv = (old_mode == 1) && (m_mode == 1) && step && !stall;
`else
      m_fv = (m_mode == 1) && !stall;
`endif
      m_halt = (m_mode == 2);
      if (upd) begin
         m_pc = nxt;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (m_cnt_s != 15) m_cnt_s = m_cnt_s + 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("pc",     bus.pc_o,          m_pc);
      check("fv",     bus.fetch_valid_o, m_fv);
      check("halted", bus.halted_o,      m_halt);
      check("cnt",    bus.fetch_cnt_o,   m_cnt);
      check("cnt_s",  bus_s.fetch_cnt_o, m_cnt_s);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
`ifdef PC_STEP_EN
      step = 1'b1;   // held high: one update per cycle during the directed part
`endif
      // 1. reset and straight-line fetch
      rst_n = 1'b0;
      tick(); tick();
      check("rst_pc", bus.pc_o, 0);
      check("rst_fv", bus.fetch_valid_o, 0);
      check("rst_halted", bus.halted_o, 0);
      check("rst_cnt", bus.fetch_cnt_o, 0);
      rst_n = 1'b1; en = 1'b1;
      tick();
      check("t1_start_pc", bus.pc_o, 0);
      check("t1_start_cnt", bus.fetch_cnt_o, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t1_pc", bus.pc_o, i);
         check("t1_cnt", bus.fetch_cnt_o, i);
      end
      check("t1_fv", bus.fetch_valid_o, 1);
      tick(); tick();
      check("t1_pc5", bus.pc_o, 5);

      // 2. redirect beats stall; jump beats branch
      br = 1'b1; bt = 32'h40; stall = 1'b1;
      tick();
      check("t2_branch_over_stall", bus.pc_o, 32'h40);
      br = 1'b0; stall = 1'b0;
      jmp = 1'b1; jt = 32'h80; br = 1'b1; bt = 32'h90;
      tick();
      check("t2_jump_over_branch", bus.pc_o, 32'h80);
      br = 1'b0;

      // 3. three-cycle stall at pc 7
      jt = 32'h7;
      tick();
      jmp = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_pc_held", bus.pc_o, 7);
         check("t3_fv_low", bus.fetch_valid_o, 0);
         check("t3_cnt_held", bus.fetch_cnt_o, 8);
      end
      stall = 1'b0;
      tick();
      check("t3_resume", bus.pc_o, 8);

      // 4. halt is sticky, only reset clears it
      jmp = 1'b1; jt = 32'h9;
      tick();
      jmp = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0;
      check("t4_halt_pc", bus.pc_o, 9);
      check("t4_halted", bus.halted_o, 1);
      jmp = 1'b1; jt = 32'h123;
      for (int i = 0; i < 4; i++) begin
         en = i[0];
         tick();
         check("t4_frozen_pc", bus.pc_o, 9);
         check("t4_still_halted", bus.halted_o, 1);
      end
      jmp = 1'b0; en = 1'b0; rst_n = 1'b0;
      tick();
      check("t4_reset_pc", bus.pc_o, 0);
      check("t4_reset_halted", bus.halted_o, 0);
      rst_n = 1'b1;

      // 5. wrap-around and counter saturation
      en = 1'b1;
      tick();
      jmp = 1'b1; jt = 32'hFFFF_FFFF;
      tick();
      jmp = 1'b0;
      check("t5_top", bus.pc_o, 32'hFFFF_FFFF);
      tick();
      check("t5_wrap", bus.pc_o, 0);
      repeat (20) tick();
      check("t5_sat_small", bus_s.fetch_cnt_o, 15);
      check("t5_cnt_large", bus.fetch_cnt_o, 22);

`ifdef PC_STEP_EN
      // 6. isolated single-step pulses
      rst_n = 1'b0; step = 1'b0;
      tick();
      rst_n = 1'b1; en = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         step = 1'b1;
         tick();
         check("t6_step_pc", bus.pc_o, k);
         step = 1'b0;
         repeat (4) begin
            tick();
            check("t6_idle_pc", bus.pc_o, k);
            check("t6_idle_fv", bus.fetch_valid_o, 0);
         end
      end
`endif

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(32) != 0);
         en    = ($urandom_range(9) != 0);
         stall = ($urandom_range(3) == 0);
         br    = ($urandom_range(6) == 0);
         bt    = $urandom;
         jmp   = ($urandom_range(9) == 0);
         jt    = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
         halt  = ($urandom_range(59) == 0);
         skew  = ($urandom_range(4) == 0) ? 32'($urandom_range(7)) : 32'd0;
         step  = ($urandom_range(1) == 1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
